dma_priority_resolver: RTL and testbench
========================================

Name: dma_priority_resolver

Overview:
- Channel request/acknowledge stage of the 8237-style DMA controller.
- Samples the DREQ pins and merges in software requests and channel masks.
- Resolves fixed or rotating priority across 4 channels and raises a service request toward timing-and-control.
- Drives DACK from timing-and-control's assertDACK/deassertDACK strobes, and reports the active channel to the datapath.

Parameters:
- NUM_CH, 4, number of DMA channels.
- CH_W, 2, channel index width, equal to $clog2(NUM_CH).

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  synchronous, active-high reset.
- DREQ  in  NUM_CH  raw channel request pins, polarity per dreqSenseLow.
- maskReg  in  NUM_CH  1 = channel masked (hardware DREQ ignored).
- requestReg  in  NUM_CH  software request bits; not affected by mask.
- rotatingPriority  in  1  0 = fixed priority (ch0 highest), 1 = rotating.
- dreqSenseLow  in  1  1 = DREQ active-low.
- dackSenseHigh  in  1  1 = DACK active-high.
- assertDACK  in  1  strobe from timing-and-control: grant the pending channel.
- deassertDACK  in  1  strobe from timing-and-control: service finished.
- DACK  out  NUM_CH  channel acknowledges, polarity per dackSenseHigh.
- validDREQ  out  1  a channel is pending or in service; drives the HRQ path.
- activeChannel  out  CH_W  index of the pending or serviced channel.

Behaviour:
- Effective request per cycle: eff = ((dreqSenseLow ? ~DREQ : DREQ) & ~maskReg) | requestReg.
- Registered request stage: reqQ <= eff every cycle. One cycle of sampling latency.
- State machine (registered) with states IDLE, PENDING and SERVICE.
  - IDLE: if reqQ != 0, latch the winner into activeChannel and go to PENDING. validDREQ = 1 from the next cycle.
  - PENDING, assertDACK = 1: go to SERVICE. The DACK bit for activeChannel goes active the same edge.
  - PENDING, assertDACK = 0 and reqQ[activeChannel] = 0: return to IDLE and clear validDREQ. Higher-priority arrivals do not preempt a latched channel.
  - SERVICE, deassertDACK = 1: DACK goes inactive, state goes to IDLE, validDREQ clears. Requests are re-arbitrated from IDLE on the following cycle, so there is a minimum one idle cycle between services.
  - SERVICE: reqQ changes are ignored; the channel holds DACK until deassertDACK.
- Strobes outside their state are ignored: assertDACK outside PENDING, deassertDACK outside SERVICE. If both strobes are asserted in PENDING, assertDACK wins.
- Priority:
  - Fixed mode: lowest index wins.
  - Rotating mode: search order starts at (lastServed+1) mod NUM_CH.
  - lastServed updates on every SERVICE -> IDLE exit, in either mode. Switching modes takes effect at the next arbitration.
  - Modulo wrap is natural CH_W-bit overflow.
- DACK output:
  - Internal one-hot dackInt (1 = active) is registered.
  - Output is DACK = dackSenseHigh ? dackInt : ~dackInt. The polarity mapping is combinational, so a polarity change takes effect immediately.
- Reset (synchronous):
  - state = IDLE, reqQ = 0, dackInt = 0 (DACK at inactive level), validDREQ = 0, activeChannel = 0.
  - lastServed = NUM_CH-1, so ch0 is highest priority after reset.
  - Reset during SERVICE drops DACK on the reset edge with no deassertDACK required.

Decomposition:
- Shared package dma_pkg holds:
  - NUM_CH and CH_W constants.
  - typedef enum logic [1:0] {IDLE, PENDING, SERVICE} prio_state_t.
  - typedef logic [CH_W-1:0] ch_idx_t.
- One combinational sub-module, dma_rotating_arbiter.
  - Inputs: req[NUM_CH], startIdx, rotate.
  - Outputs: grantIdx, anyReq.
  - Reused by the wrapper FSM.

Test Plan:
- Fixed priority, reset, DREQ = 4'b1010 active-high, no mask, then assertDACK -> activeChannel = 1, validDREQ = 1 two cycles after DREQ. DACK = 4'b0010 after assertDACK (dackSenseHigh = 1).
- Rotating mode: ch1 is serviced and ends with deassertDACK while DREQ = 4'b1011 is held -> next grant is ch3, then ch0, then ch1.
- maskReg = 4'b0001 with DREQ[0] = 1 -> validDREQ stays 0. Then requestReg = 4'b0001 -> ch0 granted despite the mask.
- PENDING on ch2 and DREQ[2] drops before assertDACK -> state returns to IDLE, validDREQ = 0, DACK stays inactive.
- dreqSenseLow = 1, dackSenseHigh = 0, DREQ = 4'b1110 -> ch0 wins. After assertDACK, DACK = 4'b1110; after deassertDACK, DACK = 4'b1111.
- RESET asserted in SERVICE on ch3 -> the next edge gives DACK inactive, validDREQ = 0, state IDLE. After reset, with rotatingPriority = 1 and DREQ = 4'b1001, ch0 wins.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared constants and types for the DMA channel request/acknowledge stage.
//   NUM_CH       : number of DMA channels
//   CH_W         : channel index width
//   prio_state_t : resolver FSM state encoding
//   ch_idx_t     : channel index type
package dma_pkg;
    localparam int NUM_CH = 4;
    localparam int CH_W   = $clog2(NUM_CH);

    typedef enum logic [1:0] {IDLE, PENDING, SERVICE} prio_state_t;

    typedef logic [CH_W-1:0] ch_idx_t;
endpackage

// File: rtl/dma_rotating_arbiter.sv
// Combinational priority search over NUM_CH request bits.
// Ports:
//   req      in  NUM_CH  request vector
//   startIdx in  CH_W    first index searched when rotating
//   rotate   in  1       0 = search from index 0, 1 = search from startIdx
//   grantIdx out CH_W    first requesting index in search order (0 if none)
//   anyReq   out 1       at least one request bit set
module dma_rotating_arbiter
    import dma_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  ch_idx_t           startIdx,
    input  logic              rotate,
    output ch_idx_t           grantIdx,
    output logic              anyReq
);

    ch_idx_t w_base;
    ch_idx_t w_idx;
    logic    w_found;

    always_comb begin
        w_base   = rotate ? startIdx : '0;
        w_idx    = '0;
        w_found  = 1'b0;
        grantIdx = '0;
        // Index arithmetic wraps naturally at CH_W bits.
        for (int k = 0; k < NUM_CH; k++) begin
            w_idx = w_base + ch_idx_t'(k);
            if (!w_found && req[w_idx]) begin
                grantIdx = w_idx;
                w_found  = 1'b1;
            end
        end
    end

    assign anyReq = |req;

endmodule

// File: rtl/dma_priority_resolver.sv
// Channel request/acknowledge stage of an 8237-style DMA controller.
// Samples DREQ, merges software requests and masks, resolves fixed or
// rotating priority, and drives DACK from timing-and-control strobes.
// Ports:
//   CLK, RESET        clock and synchronous active-high reset
//   DREQ              raw channel requests (polarity per dreqSenseLow)
//   maskReg           1 = hardware DREQ ignored for that channel
//   requestReg        software requests, bypass the mask
//   rotatingPriority  0 = fixed (ch0 highest), 1 = rotating
//   dreqSenseLow      1 = DREQ active-low
//   dackSenseHigh     1 = DACK active-high
//   assertDACK        grant the pending channel
//   deassertDACK      service finished
//   DACK              channel acknowledges (polarity per dackSenseHigh)
//   validDREQ         a channel is pending or in service
//   activeChannel     index of the pending or serviced channel
//
// state   | meaning
// IDLE    | no channel latched; arbitrate registered requests
// PENDING | winner latched, waiting for assertDACK
// SERVICE | DACK held for activeChannel until deassertDACK
module dma_priority_resolver
    import dma_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic [NUM_CH-1:0] maskReg,
    input  logic [NUM_CH-1:0] requestReg,
    input  logic              rotatingPriority,
    input  logic              dreqSenseLow,
    input  logic              dackSenseHigh,
    input  logic              assertDACK,
    input  logic              deassertDACK,
    output logic [NUM_CH-1:0] DACK,
    output logic              validDREQ,
    output ch_idx_t           activeChannel
);

    prio_state_t       r_state;
    logic [NUM_CH-1:0] r_req_q;
    ch_idx_t           r_active_ch;
    logic [NUM_CH-1:0] r_dack_int;
    ch_idx_t           r_last_served;

    prio_state_t       w_state_nxt;
    ch_idx_t           w_active_nxt;
    logic [NUM_CH-1:0] w_dack_nxt;
    ch_idx_t           w_last_nxt;
    logic [NUM_CH-1:0] w_eff;
    ch_idx_t           w_start;
    ch_idx_t           w_grant;
    logic              w_any;

    assign w_eff   = ((dreqSenseLow ? ~DREQ : DREQ) & ~maskReg) | requestReg;
    assign w_start = r_last_served + ch_idx_t'(1);

    dma_rotating_arbiter u_arb (
        .req      (r_req_q),
        .startIdx (w_start),
        .rotate   (rotatingPriority),
        .grantIdx (w_grant),
        .anyReq   (w_any)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= IDLE;
            r_req_q       <= '0;
            r_active_ch   <= '0;
            r_dack_int    <= '0;
            r_last_served <= ch_idx_t'(NUM_CH - 1);
        end else begin
            r_state       <= w_state_nxt;
            r_req_q       <= w_eff;
            r_active_ch   <= w_active_nxt;
            r_dack_int    <= w_dack_nxt;
            r_last_served <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_active_nxt = r_active_ch;
        w_dack_nxt   = r_dack_int;
        w_last_nxt   = r_last_served;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_active_nxt = w_grant;
                    w_state_nxt  = PENDING;
                end
            end
            PENDING: begin
                // assertDACK takes precedence over a request that has just dropped.
                if (assertDACK) begin
                    w_dack_nxt  = {{(NUM_CH-1){1'b0}}, 1'b1} << r_active_ch;
                    w_state_nxt = SERVICE;
                end else if (!r_req_q[r_active_ch]) begin
                    w_state_nxt = IDLE;
                end
            end
            SERVICE: begin
                if (deassertDACK) begin
                    w_dack_nxt  = '0;
                    w_last_nxt  = r_active_ch;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_dack_nxt  = '0;
            end
        endcase
    end

    assign validDREQ     = (r_state != IDLE);
    assign activeChannel = r_active_ch;
    assign DACK          = dackSenseHigh ? r_dack_int : ~r_dack_int;

endmodule

// File: tb/tb_dma_priority_resolver.sv
module tb_dma_priority_resolver;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] DREQ;
    logic [3:0] maskReg;
    logic [3:0] requestReg;
    logic       rotatingPriority;
    logic       dreqSenseLow;
    logic       dackSenseHigh;
    logic       assertDACK;
    logic       deassertDACK;
    logic [3:0] DACK;
    logic       validDREQ;
    logic [1:0] activeChannel;

    int checks = 0;
    int errors = 0;
    bit run = 1'b0;

    dma_priority_resolver u_dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .DREQ             (DREQ),
        .maskReg          (maskReg),
        .requestReg       (requestReg),
        .rotatingPriority (rotatingPriority),
        .dreqSenseLow     (dreqSenseLow),
        .dackSenseHigh    (dackSenseHigh),
        .assertDACK       (assertDACK),
        .deassertDACK     (deassertDACK),
        .DACK             (DACK),
        .validDREQ        (validDREQ),
        .activeChannel    (activeChannel)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: channel waiting for a grant, channel being serviced
    // (-1 = none), last serviced channel and the one-cycle-delayed request word.
    int         m_pend = -1;
    int         m_serv = -1;
    int         m_last = 3;
    logic [3:0] m_reqq = 4'b0000;
    logic [3:0] m_old;

    function automatic int pick(input logic [3:0] r, input bit rot, input int last);
        int idx;
        for (int k = 0; k < 4; k++) begin
            idx = rot ? (last + 1 + k) % 4 : k;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    always @(posedge CLK) begin
        if (RESET) begin
            m_pend = -1;
            m_serv = -1;
            m_last = 3;
            m_reqq = 4'b0000;
        end else begin
            m_old  = m_reqq;
            m_reqq = ((dreqSenseLow ? ~DREQ : DREQ) & ~maskReg) | requestReg;
            if (m_serv >= 0) begin
                if (deassertDACK) begin
                    m_last = m_serv;
                    m_serv = -1;
                end
            end else if (m_pend >= 0) begin
                if (assertDACK) begin
                    m_serv = m_pend;
                    m_pend = -1;
                end else if (!m_old[m_pend]) begin
                    m_pend = -1;
                end
            end else if (m_old != 4'b0000) begin
                m_pend = pick(m_old, rotatingPriority, m_last);
            end
        end
    end

    logic [3:0] e_dack;
    bit         e_valid;

    always @(negedge CLK) begin
        if (run) begin
            e_valid = (m_pend >= 0) || (m_serv >= 0);
            e_dack  = (m_serv >= 0) ? (4'b0001 << m_serv) : 4'b0000;
            if (!dackSenseHigh) e_dack = ~e_dack;
            chk("sb_valid", int'(validDREQ), int'(e_valid));
            chk("sb_dack", int'(DACK), int'(e_dack));
            if (e_valid) chk("sb_chan", int'(activeChannel), (m_pend >= 0) ? m_pend : m_serv);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic grant_and_finish();
        assertDACK = 1'b1;
        cyc();
        assertDACK   = 1'b0;
        deassertDACK = 1'b1;
        cyc();
        deassertDACK = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; DREQ = 4'b0000; maskReg = 4'b0000; requestReg = 4'b0000;
        rotatingPriority = 1'b0; dreqSenseLow = 1'b0; dackSenseHigh = 1'b1;
        assertDACK = 1'b0; deassertDACK = 1'b0;
        cyc();
        run = 1'b1;
        cyc();
        chk("rst_dack", int'(DACK), 'h0);
        chk("rst_valid", int'(validDREQ), 0);
        chk("rst_chan", int'(activeChannel), 0);

        // Fixed priority, two-cycle latency, both strobes in PENDING.
        RESET = 1'b0; DREQ = 4'b1010;
        cyc();
        chk("s1_latency", int'(validDREQ), 0);
        cyc();
        chk("s1_valid", int'(validDREQ), 1);
        chk("s1_chan", int'(activeChannel), 1);
        assertDACK = 1'b1; deassertDACK = 1'b1;
        cyc();
        assertDACK = 1'b0; deassertDACK = 1'b0;
        chk("s1_dack", int'(DACK), 'h2);
        cyc();
        chk("s1_hold", int'(DACK), 'h2);
        deassertDACK = 1'b1; DREQ = 4'b0000;
        cyc();
        deassertDACK = 1'b0;
        chk("s1_release", int'(DACK), 'h0);
        chk("s1_release_valid", int'(validDREQ), 0);
        cyc(2);

        // Rotating priority after ch1 service with 1011 held.
        rotatingPriority = 1'b1; DREQ = 4'b0010;
        cyc(2);
        chk("s2_first", int'(activeChannel), 1);
        assertDACK = 1'b1;
        cyc();
        assertDACK = 1'b0; DREQ = 4'b1011;
        cyc(2);
        chk("s2_hold", int'(DACK), 'h2);
        deassertDACK = 1'b1;
        cyc();
        deassertDACK = 1'b0;
        chk("s2_idle_gap", int'(validDREQ), 0);
        cyc();
        chk("s2_next_ch3", int'(activeChannel), 3);
        grant_and_finish();
        cyc();
        chk("s2_wrap_ch0", int'(activeChannel), 0);
        grant_and_finish();
        cyc();
        chk("s2_third_ch1", int'(activeChannel), 1);
        assertDACK = 1'b1;
        cyc();
        assertDACK = 1'b0; DREQ = 4'b0000; deassertDACK = 1'b1;
        cyc();
        deassertDACK = 1'b0;
        cyc(2);

        // Mask blocks DREQ, software request bypasses mask.
        rotatingPriority = 1'b0; maskReg = 4'b0001; DREQ = 4'b0001;
        cyc(3);
        chk("s3_masked", int'(validDREQ), 0);
        requestReg = 4'b0001;
        cyc(2);
        chk("s3_swreq_valid", int'(validDREQ), 1);
        chk("s3_swreq_chan", int'(activeChannel), 0);
        requestReg = 4'b0000; maskReg = 4'b0000; DREQ = 4'b0000;
        cyc(2);
        chk("s3_drop", int'(validDREQ), 0);

        // Request withdrawn while pending.
        DREQ = 4'b0100;
        cyc(2);
        chk("s4_pend", int'(activeChannel), 2);
        DREQ = 4'b0000;
        cyc(2);
        chk("s4_valid", int'(validDREQ), 0);
        chk("s4_dack", int'(DACK), 'h0);
        assertDACK = 1'b1;
        cyc();
        assertDACK = 1'b0;
        chk("s4_stray_assert", int'(DACK), 'h0);

        // Active-low DREQ, active-low DACK.
        dreqSenseLow = 1'b1; dackSenseHigh = 1'b0; DREQ = 4'b1110;
        #1;
        chk("s5_idle_dack", int'(DACK), 'hF);
        cyc(2);
        chk("s5_chan", int'(activeChannel), 0);
        assertDACK = 1'b1;
        cyc();
        assertDACK = 1'b0;
        chk("s5_dack_on", int'(DACK), 'hE);
        DREQ = 4'b1111; deassertDACK = 1'b1;
        cyc();
        deassertDACK = 1'b0;
        chk("s5_dack_off", int'(DACK), 'hF);
        dreqSenseLow = 1'b0; dackSenseHigh = 1'b1; DREQ = 4'b0000;
        cyc(2);

        // Reset during SERVICE, then rotating arbitration restarts at ch0.
        DREQ = 4'b1000;
        cyc(2);
        chk("s6_chan", int'(activeChannel), 3);
        assertDACK = 1'b1;
        cyc();
        assertDACK = 1'b0;
        chk("s6_dack", int'(DACK), 'h8);
        RESET = 1'b1;
        cyc();
        chk("s6_rst_dack", int'(DACK), 'h0);
        chk("s6_rst_valid", int'(validDREQ), 0);
        RESET = 1'b0; rotatingPriority = 1'b1; DREQ = 4'b1001;
        cyc(2);
        chk("s6_after_rst", int'(activeChannel), 0);
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
